// File: rtl/fir_capture_buffer.sv
// fir_capture_buffer
//   Capture buffer for the FIR output stream. Samples are stored in a DEPTH-entry
//   RAM while the capture FSM is armed. The RAM, STATUS and CONTROL registers are
//   exposed in one Avalon-MM slave window.
//
//   Optional feature: define FIR_CAPBUF_IRQ_EN to get the irq port and its logic.
//
// State table
//   state   | meaning
//   IDLE    | not capturing, samples dropped
//   CAPTURE | storing each in_valid sample at wr_ptr
//   DONE    | one-shot buffer full, samples dropped and flagged as overflow
//
// Ports
//   clk, reset          system clock, async active-high reset
//   in_valid, in_data   sample stream from the FIR core
//   read, write         Avalon strobes (write wins when both are high)
//   address             Avalon word address
//   writedata           Avalon write data
//   readdata            registered read data, 1-cycle latency
//   readdatavalid       pulses one cycle after each accepted read
//   irq                 (FIR_CAPBUF_IRQ_EN only) capture-complete / wrap interrupt
module fir_capture_buffer #(
  parameter int DATA_W    = 16,
  parameter int DEPTH     = 2048,
  parameter int ADDR_W    = 18,
  parameter int BASE_ADDR = 12288
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              read,
  input  logic              write,
  input  logic [ADDR_W-1:0] address,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic              readdatavalid
`ifdef FIR_CAPBUF_IRQ_EN
  ,
  output logic              irq
`endif
);

  localparam int PTR_W = $clog2(DEPTH);

  localparam logic [ADDR_W-1:0] RAM_LO  = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] STAT_A  = ADDR_W'(BASE_ADDR + DEPTH);
  localparam logic [ADDR_W-1:0] CTRL_A  = ADDR_W'(BASE_ADDR + DEPTH + 1);
  localparam logic [PTR_W:0]    DEPTH_C = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W-1:0]  PTR_MAX = PTR_W'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, CAPTURE, DONE} state_t;

  state_t state, state_next;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W:0]    count;
  logic [PTR_W:0]    count_inc;
  logic              full, wrapped, overflow, mode;

  logic              in_ram, ctrl_wr, rd_acc;
  logic              do_clear, do_arm, take, drop_done, fill_done;
  logic [PTR_W-1:0]  ram_idx;
  logic [31:0]       status, ctrl_rb;

  assign in_ram    = (address >= RAM_LO) && (address < STAT_A);
  assign ram_idx   = PTR_W'(address - RAM_LO);
  assign ctrl_wr   = write && (address == CTRL_A);
  assign rd_acc    = read && !write;
  // CLEAR beats ARM; any CONTROL write steals the cycle from a sample.
  assign do_clear  = ctrl_wr && writedata[2];
  assign do_arm    = ctrl_wr && writedata[0] && !writedata[2];
  assign take      = in_valid && !ctrl_wr && (state == CAPTURE);
  assign drop_done = in_valid && !ctrl_wr && (state == DONE);
  assign count_inc = count + (PTR_W+1)'(1);
  assign fill_done = take && !mode && (count_inc >= DEPTH_C);

`ifdef FIR_CAPBUF_IRQ_EN
  logic irq_en;
  logic set_irq;
  logic unused_bits;
  assign unused_bits = ^writedata[31:4];
  assign set_irq     = irq_en && (fill_done || (take && mode && (wr_ptr == PTR_MAX) && !wrapped));
  assign ctrl_rb     = {28'd0, irq_en, 1'b0, mode, 1'b0};
`else
  logic unused_bits;
  assign unused_bits = ^writedata[31:3];
  assign ctrl_rb     = {30'd0, mode, 1'b0};
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (do_clear)       state_next = IDLE;
    else if (do_arm)    state_next = CAPTURE;
    else if (fill_done) state_next = DONE;
  end

  always_comb begin
    status          = '0;
    status[PTR_W:0] = count;
    status[16]      = full;
    status[17]      = wrapped;
    status[18]      = overflow;
    status[19]      = (state == CAPTURE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      count    <= '0;
      full     <= 1'b0;
      wrapped  <= 1'b0;
      overflow <= 1'b0;
    end else if (do_clear || do_arm) begin
      wr_ptr   <= '0;
      count    <= '0;
      full     <= 1'b0;
      wrapped  <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (take) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
        if (!mode) begin
          if (fill_done) begin
            count <= DEPTH_C;
            full  <= 1'b1;
          end else begin
            count <= count_inc;
          end
        end else begin
          if (count < DEPTH_C) count <= count_inc;
          if (wr_ptr == PTR_MAX) wrapped <= 1'b1;
        end
      end
      if (drop_done) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode <= 1'b0;
`ifdef FIR_CAPBUF_IRQ_EN
      irq_en <= 1'b0;
`endif
    end else if (ctrl_wr) begin
      mode <= writedata[1];
`ifdef FIR_CAPBUF_IRQ_EN
      irq_en <= writedata[3];
`endif
    end
  end

`ifdef FIR_CAPBUF_IRQ_EN
  // A new interrupt event wins over a STATUS read acknowledging the old one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                  irq <= 1'b0;
    else if (do_clear)                          irq <= 1'b0;
    else if (set_irq)                           irq <= 1'b1;
    else if (rd_acc && (address == STAT_A))     irq <= 1'b0;
  end
`endif

  always_ff @(posedge clk) begin
    if (take) mem[wr_ptr] <= in_data;
  end

  // mem is read before the same-edge write lands, so a collision returns old data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      readdata      <= '0;
      readdatavalid <= 1'b0;
    end else begin
      readdatavalid <= rd_acc;
      if (rd_acc) begin
        if (in_ram)                 readdata <= 32'(mem[ram_idx]);
        else if (address == STAT_A) readdata <= status;
        else if (address == CTRL_A) readdata <= ctrl_rb;
        else                        readdata <= '0;
      end
    end
  end

endmodule
